// File: rtl/dll_pkg.sv
// Shared types and constants for the DLL delay-code controller:
// FSM state encoding, step direction values and the default code width.
package dll_pkg;

  localparam int DLL_CODE_W = 10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    ST_SARRST = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2
  } dll_state_e;

endpackage

// File: rtl/dll_track_ctrl_if.sv
// Bundle between the DLL controller, the SAR and the phase comparator.
// There is no valid/ready handshake: comp and restart are sampled on every clk4 edge.
interface dll_track_ctrl_if import dll_pkg::*; #(
  parameter int WIDTH = DLL_CODE_W
);
  logic             comp;
  logic             restart;
  logic [WIDTH-1:0] sar_q;
  logic             sar_rst_n;
  logic [WIDTH-1:0] code;
  logic             tracking;
  logic             lock;

  modport master (
    input  comp, restart, sar_q,
    output sar_rst_n, code, tracking, lock
  );

  modport slave (
    output comp, restart, sar_q,
    input  sar_rst_n, code, tracking, lock
  );
endinterface

// File: rtl/dll_vote_filter.sv
// Signed majority filter on the phase comparator: emits a single-cycle step_up/step_dn
// when the net vote reaches +/-VOTE_TH, then restarts the count from zero.
module dll_vote_filter import dll_pkg::*; #(
  parameter int VOTE_TH = 4
) (
  input  logic clk4,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic comp,
  output logic step_up,
  output logic step_dn
);
  localparam int AW = $clog2(VOTE_TH) + 2;
  localparam logic signed [AW-1:0] ONE    = 1;
  localparam logic signed [AW-1:0] TH_POS = AW'(VOTE_TH);
  localparam logic signed [AW-1:0] TH_NEG = -TH_POS;

  logic signed [AW-1:0] acc_q, acc_d, acc_nxt;

  always_comb begin
    acc_nxt = comp ? (acc_q + ONE) : (acc_q - ONE);
    step_up = en && !clr && (acc_nxt == TH_POS);
    step_dn = en && !clr && (acc_nxt == TH_NEG);
    acc_d   = acc_q;
    if (clr || step_up || step_dn) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk4) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dll_track_ctrl.sv
// DLL delay-code controller: runs the SAR coarse search, captures its code, then
// owns the code with filtered +/-1 tracking and reports lock.
module dll_track_ctrl import dll_pkg::*; #(
  parameter int WIDTH         = DLL_CODE_W,
  parameter int SEARCH_CYCLES = 10,
  parameter int VOTE_TH       = 4,
  parameter int LOCK_FLIPS    = 4,
  parameter int UNLOCK_RUN    = 8
) (
  input  logic       clk4,
  input  logic       rst,
  dll_track_ctrl_if.master bus,
  output dll_state_e dbg_state
);
  localparam int SCW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int FW  = $clog2(LOCK_FLIPS + 1);
  localparam int RW  = $clog2(UNLOCK_RUN + 1);
  localparam logic [SCW-1:0]   SEARCH_LAST = SCW'(SEARCH_CYCLES - 1);
  localparam logic [FW-1:0]    FLIPS_MAX   = FW'(LOCK_FLIPS);
  localparam logic [RW-1:0]    RUN_MAX     = RW'(UNLOCK_RUN);
  localparam logic [RW-1:0]    RUN_ONE     = RW'(1);
  localparam logic [WIDTH-1:0] CODE_MAX    = {WIDTH{1'b1}};

  dll_state_e       state_q, state_d;
  logic [SCW-1:0]   search_cnt_q, search_cnt_d;
  logic [WIDTH-1:0] track_code_q, track_code_d;
  logic [FW-1:0]    flip_cnt_q, flip_cnt_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic             last_dir_q, last_dir_d;
  logic             lock_q, lock_d;
  logic             sar_rst_n_q, sar_rst_n_d;
  logic             in_track, step_up, step_dn;

  assign in_track = (state_q == ST_TRACK);

  dll_vote_filter #(.VOTE_TH(VOTE_TH)) u_vote (
    .clk4    (clk4),
    .rst     (rst),
    .clr     (bus.restart),
    .en      (in_track),
    .comp    (bus.comp),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  // State register together with the datapath flops it sequences.
  always_ff @(posedge clk4) begin
    if (rst) begin
      state_q      <= ST_SARRST;
      sar_rst_n_q  <= 1'b0;
      search_cnt_q <= '0;
      track_code_q <= '0;
      flip_cnt_q   <= '0;
      run_cnt_q    <= '0;
      last_dir_q   <= DIR_DN;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sar_rst_n_q  <= sar_rst_n_d;
      search_cnt_q <= search_cnt_d;
      track_code_q <= track_code_d;
      flip_cnt_q   <= flip_cnt_d;
      run_cnt_q    <= run_cnt_d;
      last_dir_q   <= last_dir_d;
      lock_q       <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = ST_SARRST;
    end else begin
      case (state_q)
        ST_SARRST: state_d = ST_SEARCH;
        ST_SEARCH: if (search_cnt_q == SEARCH_LAST) state_d = ST_TRACK;
        ST_TRACK:  state_d = ST_TRACK;
        default:   state_d = ST_SARRST;
      endcase
    end
    // SAR reset comes straight from a flop so the asynchronous SAR reset never glitches.
    sar_rst_n_d = (state_d != ST_SARRST);
  end

  always_comb begin
    search_cnt_d = search_cnt_q;
    track_code_d = track_code_q;
    flip_cnt_d   = flip_cnt_q;
    run_cnt_d    = run_cnt_q;
    last_dir_d   = last_dir_q;
    lock_d       = lock_q;
    if (bus.restart) begin
      search_cnt_d = '0;
      flip_cnt_d   = '0;
      run_cnt_d    = '0;
      lock_d       = 1'b0;
    end else begin
      case (state_q)
        ST_SARRST: search_cnt_d = '0;
        ST_SEARCH: begin
          if (search_cnt_q == SEARCH_LAST) begin
            search_cnt_d = '0;
            track_code_d = bus.sar_q;
          end else begin
            search_cnt_d = search_cnt_q + 1'b1;
          end
        end
        ST_TRACK: begin
          if (step_up || step_dn) begin
            // A saturated code still counts as a step for lock bookkeeping.
            if (step_up) begin
              if (track_code_q != CODE_MAX) track_code_d = track_code_q + 1'b1;
            end else begin
              if (track_code_q != '0) track_code_d = track_code_q - 1'b1;
            end
            if (step_up != last_dir_q) begin
              flip_cnt_d = (flip_cnt_q == FLIPS_MAX) ? flip_cnt_q : flip_cnt_q + 1'b1;
              run_cnt_d  = RUN_ONE;
            end else begin
              run_cnt_d  = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
              flip_cnt_d = '0;
            end
            last_dir_d = step_up ? DIR_UP : DIR_DN;
            if (flip_cnt_d == FLIPS_MAX) begin
              lock_d = 1'b1;
            end else if (run_cnt_d == RUN_MAX) begin
              lock_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.sar_rst_n = sar_rst_n_q;
    bus.tracking  = in_track;
    bus.lock      = lock_q;
    bus.code      = in_track ? track_code_q : bus.sar_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_dll_track_ctrl.sv
// Directed bench for dll_track_ctrl: a bit-serial SAR model drives sar_q, a spec-level
// cycle model predicts every output, and literal checks pin the model at key points.
module tb_dll_track_ctrl;
  import dll_pkg::*;

  localparam int W   = 10;
  localparam int SC  = 10;
  localparam int VT  = 4;
  localparam int LF  = 4;
  localparam int UR  = 8;
  localparam int EW  = 2 + 3 + W;

  typedef struct {
    string nm;
    int    act;
    int    exp;
  } lit_t;

  logic       clk4;
  logic       rst;
  dll_state_e dbg_state;
  dll_track_ctrl_if #(.WIDTH(W)) bus ();

  dll_track_ctrl #(
    .WIDTH(W), .SEARCH_CYCLES(SC), .VOTE_TH(VT), .LOCK_FLIPS(LF), .UNLOCK_RUN(UR)
  ) dut (
    .clk4      (clk4),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk4 = 1'b0;
    forever #5 clk4 = ~clk4;
  end

  // SAR model: resolves one bit per edge from the MSB, trial bit set one below.
  logic [W-1:0] sar_target;
  int           sar_bit;
  logic [W-1:0] sar_t;
  always @(posedge clk4 or negedge bus.sar_rst_n) begin
    if (!bus.sar_rst_n || rst) begin
      bus.sar_q <= 10'h200;
      sar_bit   <= W - 1;
    end else if (sar_bit >= 0) begin
      sar_t = bus.sar_q;
      sar_t[sar_bit] = sar_target[sar_bit];
      if (sar_bit > 0) sar_t[sar_bit-1] = 1'b1;
      bus.sar_q <= sar_t;
      sar_bit   <= sar_bit - 1;
    end
  end

  // Behavioural model of the controller, one update per clk4 edge.
  logic [EW-1:0] exp_q[$];
  lit_t          lit_q[$];
  dll_state_e    m_st = ST_SARRST;
  int m_cnt = 0, m_acc = 0, m_flips = 0, m_runs = 0, m_code = 0;
  bit m_last = 0, m_lock = 0;

  task automatic take_step(input bit up);
    if (up)  m_code = (m_code < (1 << W) - 1) ? m_code + 1 : m_code;
    else     m_code = (m_code > 0) ? m_code - 1 : 0;
    if (up != m_last) begin
      m_flips = (m_flips + 1 > LF) ? LF : m_flips + 1;
      m_runs  = 1;
    end else begin
      m_runs  = (m_runs + 1 > UR) ? UR : m_runs + 1;
      m_flips = 0;
    end
    m_last = up;
    if (m_flips == LF) m_lock = 1;
    else if (m_runs == UR) m_lock = 0;
  endtask

  always @(posedge clk4) begin
    if (rst || bus.restart) begin
      m_st = ST_SARRST; m_cnt = 0; m_acc = 0; m_flips = 0; m_runs = 0; m_lock = 0;
      if (rst) begin m_last = 0; m_code = 0; end
    end else if (m_st == ST_SARRST) begin
      m_st = ST_SEARCH; m_cnt = 0;
    end else if (m_st == ST_SEARCH) begin
      if (m_cnt == SC - 1) begin m_code = int'(bus.sar_q); m_st = ST_TRACK; end
      else m_cnt++;
    end else begin
      m_acc += bus.comp ? 1 : -1;
      if (m_acc == VT)       begin m_acc = 0; take_step(1'b1); end
      else if (m_acc == -VT) begin m_acc = 0; take_step(1'b0); end
    end
    exp_q.push_back({m_st, (m_st != ST_SARRST), (m_st == ST_TRACK), m_lock, W'(m_code)});
  end

  // scoreboard
  int n_vec = 0, n_err = 0;
  always @(negedge clk4) begin
    logic [EW-1:0] e;
    logic [W-1:0]  ecode;
    lit_t          l;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ecode = e[W+1] ? e[W-1:0] : bus.sar_q;
      n_vec += 5;
      if (dbg_state != dll_state_e'(e[EW-1:EW-2])) begin
        n_err++; $display("FAIL state: got %0d want %0d at %0t", dbg_state, e[EW-1:EW-2], $time);
      end
      if (bus.sar_rst_n !== e[W+2]) begin
        n_err++; $display("FAIL sar_rst_n: got %b want %b at %0t", bus.sar_rst_n, e[W+2], $time);
      end
      if (bus.tracking !== e[W+1]) begin
        n_err++; $display("FAIL tracking: got %b want %b at %0t", bus.tracking, e[W+1], $time);
      end
      if (bus.lock !== e[W]) begin
        n_err++; $display("FAIL lock: got %b want %b at %0t", bus.lock, e[W], $time);
      end
      if (bus.code !== ecode) begin
        n_err++; $display("FAIL code: got %03h want %03h at %0t", bus.code, ecode, $time);
      end
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      n_vec++;
      if (l.act != l.exp) begin
        n_err++; $display("FAIL %s: got %0h want %0h", l.nm, l.act, l.exp);
      end
    end
  end

  // driver tasks: called at a negedge, return at the following negedge
  task automatic cyc(input bit c, input bit r);
    bus.comp    = c;
    bus.restart = r;
    @(posedge clk4);
    @(negedge clk4);
  endtask

  task automatic run(input bit c, input int n);
    repeat (n) cyc(c, 1'b0);
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    lit_q.push_back('{nm, act, exp});
  endtask

  initial begin
    rst = 1'b1; bus.comp = 1'b0; bus.restart = 1'b0; sar_target = 10'h2A5;
    @(negedge clk4);
    run(0, 2);
    lit("rst_state", int'(dbg_state), int'(ST_SARRST));
    lit("rst_sar_rst_n", int'(bus.sar_rst_n), 0);
    lit("rst_tracking", int'(bus.tracking), 0);
    lit("rst_lock", int'(bus.lock), 0);

    rst = 1'b0;
    cyc(0, 0);
    lit("release_sar_rst_n", int'(bus.sar_rst_n), 1);
    lit("release_state", int'(dbg_state), int'(ST_SEARCH));
    run(0, 9);
    lit("search_9_tracking", int'(bus.tracking), 0);
    cyc(0, 0);
    lit("capture_tracking", int'(bus.tracking), 1);
    lit("capture_code", int'(bus.code), 'h2A5);

    run(1, 4);
    lit("up4_code", int'(bus.code), 'h2A6);
    run(1, 4);
    lit("up8_code", int'(bus.code), 'h2A7);
    lit("up8_lock", int'(bus.lock), 0);

    for (int g = 0; g < 10; g++) begin
      run(((g % 2) == 0), 4);
      lit("dither_lock", int'(bus.lock), (g >= 4) ? 1 : 0);
    end
    lit("dither_code", int'(bus.code), 'h2A7);
    run(1, 4);
    lit("pre_run_code", int'(bus.code), 'h2A8);

    run(0, 28);
    lit("run7_lock", int'(bus.lock), 1);
    lit("run7_code", int'(bus.code), 'h2A1);
    run(0, 4);
    lit("run8_lock", int'(bus.lock), 0);
    lit("run8_code", int'(bus.code), 'h2A0);

    for (int g = 0; g < 8; g++) run(((g % 2) == 0), 4);
    lit("relock_lock", int'(bus.lock), 1);
    lit("relock_code", int'(bus.code), 'h2A0);

    sar_target = 10'h3FF;
    cyc(0, 1);
    lit("restart_state", int'(dbg_state), int'(ST_SARRST));
    lit("restart_lock", int'(bus.lock), 0);
    lit("restart_tracking", int'(bus.tracking), 0);
    lit("restart_sar_rst_n", int'(bus.sar_rst_n), 0);
    run(0, 10);
    lit("research_tracking", int'(bus.tracking), 0);
    cyc(0, 0);
    lit("recapture_code", int'(bus.code), 'h3FF);
    lit("recapture_tracking", int'(bus.tracking), 1);

    run(1, 12);
    lit("sat_code", int'(bus.code), 'h3FF);
    lit("sat_lock", int'(bus.lock), 0);

    sar_target = 10'h155;
    rst = 1'b1;
    cyc(1, 1);
    lit("rst_restart_state", int'(dbg_state), int'(ST_SARRST));
    lit("rst_restart_sar_rst_n", int'(bus.sar_rst_n), 0);
    lit("rst_restart_code", int'(bus.code), 'h200);
    rst = 1'b0;
    run(0, 11);
    lit("final_capture_code", int'(bus.code), 'h155);
    run(0, 4);
    lit("final_dn_code", int'(bus.code), 'h154);

    @(negedge clk4);
    @(negedge clk4);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
